// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } fetch_state_t;

   localparam int DEFAULT_PC_STEP = 4;

   // Prefetch entries carry {pc, instruction}.
   function automatic int entry_width(input int addr_width, input int data_width);
      return addr_width + data_width;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, data} entries; DEPTH must be a power of two.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk_sys,
   input  logic                     rst_b,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !clear;
   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_push = push && !clear && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_push && !do_pop)
            count <= count + CNT_W'(1);
         else if (!do_push && do_pop)
            count <= count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited request issue, prefetch buffer, redirect flush.
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
//
// state | meaning
// IDLE  | first cycle after reset, no requests
// RUN   | issuing requests, buffering responses
// FLUSH | after a redirect, draining stale responses
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 32,
   parameter int                    FIFO_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                    PC_STEP      = DEFAULT_PC_STEP
) (
   input  logic                  fetch_unit_clock_in,
   input  logic                  fetch_unit_reset_in,
   output logic                  fetch_unit_imem_req_valid_out,
   input  logic                  fetch_unit_imem_req_ready_in,
   output logic [ADDR_WIDTH-1:0] fetch_unit_imem_addr_out,
   input  logic                  fetch_unit_imem_resp_valid_in,
   input  logic [DATA_WIDTH-1:0] fetch_unit_imem_data_in,
   input  logic                  fetch_unit_redirect_in,
   input  logic [ADDR_WIDTH-1:0] fetch_unit_redirect_addr_in,
   input  logic                  fetch_unit_halt_in,
   output logic                  fetch_unit_ins_valid_out,
   input  logic                  fetch_unit_ins_ready_in,
   output logic [DATA_WIDTH-1:0] fetch_unit_ins_data_out,
   output logic [ADDR_WIDTH-1:0] fetch_unit_ins_pc_out
);

   localparam int                    CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam int                    ENTRY_W      = entry_width(ADDR_WIDTH, DATA_WIDTH);
   localparam logic [CNT_W:0]        CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] STEP         = ADDR_WIDTH'(PC_STEP);

   fetch_state_t          state_q;
   fetch_state_t          state_d;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      outstanding_d;
   logic [CNT_W:0]        in_flight;
   logic                  accept;
   logic                  resp_ok;
   logic                  deliver;

   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic [ENTRY_W-1:0]    fifo_head;

   assign fetch_unit_imem_addr_out = req_pc;

   always_comb begin
      state_d       = state_q;
      in_flight     = {1'b0, fifo_count} + {1'b0, outstanding};
      fetch_unit_imem_req_valid_out = (state_q == RUN) && !fetch_unit_halt_in &&
                                      !fetch_unit_redirect_in && (in_flight < CREDIT_LIMIT);
      accept        = fetch_unit_imem_req_valid_out && fetch_unit_imem_req_ready_in;
      // A response with nothing outstanding is a memory protocol error and is ignored.
      resp_ok       = fetch_unit_imem_resp_valid_in && (outstanding != '0);
      deliver       = resp_ok && (state_q == RUN) && !fetch_unit_redirect_in;
      outstanding_d = outstanding;
      if (accept && !resp_ok)
         outstanding_d = outstanding + CNT_W'(1);
      else if (!accept && resp_ok)
         outstanding_d = outstanding - CNT_W'(1);

      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (fetch_unit_redirect_in && (outstanding_d != '0)) state_d = FLUSH;
         FLUSH:   if (!fetch_unit_redirect_in && (outstanding_d == '0)) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fetch_unit_ins_valid_out = 1'b0;
      fetch_unit_ins_data_out  = '0;
      fetch_unit_ins_pc_out    = '0;
      fifo_pop                 = 1'b0;
      fifo_push                = deliver;
`ifdef FETCH_BYPASS_EN
      if (deliver && fifo_empty) begin
         fetch_unit_ins_valid_out = 1'b1;
         fetch_unit_ins_data_out  = fetch_unit_imem_data_in;
         fetch_unit_ins_pc_out    = resp_pc;
         fifo_push                = !fetch_unit_ins_ready_in;
      end
`endif
      if (!fifo_empty && !fetch_unit_redirect_in) begin
         fetch_unit_ins_valid_out = 1'b1;
         fetch_unit_ins_pc_out    = fifo_head[ENTRY_W-1 -: ADDR_WIDTH];
         fetch_unit_ins_data_out  = fifo_head[DATA_WIDTH-1:0];
         fifo_pop                 = fetch_unit_ins_ready_in;
      end
      fifo_push = fifo_push && (!fifo_full || fifo_pop);
   end

   always_ff @(posedge fetch_unit_clock_in) begin
      if (!fetch_unit_reset_in) begin
         state_q     <= IDLE;
         req_pc      <= RESET_VECTOR;
         resp_pc     <= RESET_VECTOR;
         outstanding <= '0;
      end else begin
         state_q     <= state_d;
         outstanding <= outstanding_d;
         if (fetch_unit_redirect_in) begin
            req_pc  <= fetch_unit_redirect_addr_in;
            resp_pc <= fetch_unit_redirect_addr_in;
         end else begin
            if (accept)  req_pc  <= req_pc + STEP;
            if (deliver) resp_pc <= resp_pc + STEP;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys (fetch_unit_clock_in),
      .rst_b   (fetch_unit_reset_in),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .clear   (fetch_unit_redirect_in),
      .wr_data ({resp_pc, fetch_unit_imem_data_in}),
      .rd_data (fifo_head),
      .count   (fifo_count),
      .empty   (fifo_empty),
      .full    (fifo_full)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written corner sequences.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic        halt;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_data;
   logic [31:0] ins_pc;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .fetch_unit_clock_in           (clk),
      .fetch_unit_reset_in           (rst),
      .fetch_unit_imem_req_valid_out (req_valid),
      .fetch_unit_imem_req_ready_in  (req_ready),
      .fetch_unit_imem_addr_out      (addr),
      .fetch_unit_imem_resp_valid_in (resp_valid),
      .fetch_unit_imem_data_in       (resp_data),
      .fetch_unit_redirect_in        (redirect),
      .fetch_unit_redirect_addr_in   (redirect_addr),
      .fetch_unit_halt_in            (halt),
      .fetch_unit_ins_valid_out      (ins_valid),
      .fetch_unit_ins_ready_in       (ins_ready),
      .fetch_unit_ins_data_out       (ins_data),
      .fetch_unit_ins_pc_out         (ins_pc)
   );

   typedef struct {
      logic        rr;
      logic        rv;
      logic [31:0] rd;
      logic        ir;
      logic        ex_req;
      logic [31:0] ex_addr;
      logic        ex_iv;
      logic [31:0] ex_pc;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic ex_req, input logic [31:0] ex_addr,
                               input logic ex_iv, input logic [31:0] ex_pc);
      vec_t v;
      v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir;
      v.ex_req = ex_req; v.ex_addr = ex_addr; v.ex_iv = ex_iv; v.ex_pc = ex_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                        input logic redir, input logic [31:0] raddr,
                        input logic hlt, input logic ir);
      req_ready     = rr;
      resp_valid    = rv;
      resp_data     = rd;
      redirect      = redir;
      redirect_addr = raddr;
      halt          = hlt;
      ins_ready     = ir;
      #1;
   endtask

   task automatic step_cycle();
      @(negedge clk);
   endtask

   task automatic chk_req(input string name, input logic v, input logic [31:0] a);
      chk({name, "_req_valid"}, {31'd0, req_valid}, {31'd0, v});
      if (v) chk({name, "_addr"}, addr, a);
   endtask

   task automatic chk_ins(input string name, input logic v, input logic [31:0] pc,
                          input logic [31:0] data);
      chk({name, "_ins_valid"}, {31'd0, ins_valid}, {31'd0, v});
      if (v) begin
         chk({name, "_ins_pc"}, ins_pc, pc);
         chk({name, "_ins_data"}, ins_data, data);
      end
   endtask

   // Leaves the bench at the start of the first RUN cycle.
   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
      step_cycle();
      step_cycle();
      #1;
      chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
      chk("rst_ins_valid", {31'd0, ins_valid}, 32'd0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
      chk("rst_ins_data", ins_data, 32'h0);
      rst = 1'b1;
      #1;
      chk("idle_req_valid", {31'd0, req_valid}, 32'd0);
      step_cycle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Streaming with a 1-cycle memory, then decode back-pressure and req_ready gaps.
      tbl[0]  = mk(1, 0, 32'h0,         1, 1, 32'h00, 0, 32'h00);
      tbl[1]  = mk(1, 1, 32'h1000_0000, 1, 1, 32'h04, 0, 32'h00);
      tbl[2]  = mk(1, 1, 32'h1000_0004, 1, 1, 32'h08, 1, 32'h00);
      tbl[3]  = mk(1, 1, 32'h1000_0008, 1, 1, 32'h0C, 1, 32'h04);
      tbl[4]  = mk(1, 1, 32'h1000_000C, 0, 1, 32'h10, 1, 32'h08);
      tbl[5]  = mk(1, 1, 32'h1000_0010, 0, 1, 32'h14, 1, 32'h08);
      tbl[6]  = mk(1, 1, 32'h1000_0014, 0, 0, 32'h18, 1, 32'h08);
      tbl[7]  = mk(1, 0, 32'h0,         0, 0, 32'h18, 1, 32'h08);
      tbl[8]  = mk(1, 0, 32'h0,         1, 0, 32'h18, 1, 32'h08);
      tbl[9]  = mk(1, 0, 32'h0,         1, 1, 32'h18, 1, 32'h0C);
      tbl[10] = mk(1, 1, 32'h1000_0018, 1, 1, 32'h1C, 1, 32'h10);
      tbl[11] = mk(1, 1, 32'h1000_001C, 1, 1, 32'h20, 1, 32'h14);
      tbl[12] = mk(1, 1, 32'h1000_0020, 1, 1, 32'h24, 1, 32'h18);
      tbl[13] = mk(0, 1, 32'h1000_0024, 1, 1, 32'h28, 1, 32'h1C);
      tbl[14] = mk(0, 0, 32'h0,         1, 1, 32'h28, 1, 32'h20);
      tbl[15] = mk(1, 0, 32'h0,         1, 1, 32'h28, 1, 32'h24);
      tbl[16] = mk(0, 1, 32'h1000_0028, 1, 1, 32'h2C, 0, 32'h00);
      tbl[17] = mk(0, 0, 32'h0,         1, 1, 32'h2C, 1, 32'h28);

      do_reset();
`ifndef FETCH_BYPASS_EN
      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rr, tbl[i].rv, tbl[i].rd, 0, 32'h0, 0, tbl[i].ir);
         chk_req($sformatf("vec%0d", i), tbl[i].ex_req, tbl[i].ex_addr);
         chk_ins($sformatf("vec%0d", i), tbl[i].ex_iv, tbl[i].ex_pc,
                 32'h1000_0000 + tbl[i].ex_pc);
         step_cycle();
      end
`endif

      // Redirect with 3 outstanding on a 3-cycle memory, second redirect during FLUSH.
      do_reset();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1); chk_req("rd_c1", 1, 32'h0); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1); chk_req("rd_c2", 1, 32'h4); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1); chk_req("rd_c3", 1, 32'h8); step_cycle();
      drive(1, 1, 32'h2000_0000, 1, 32'h100, 0, 1);
      chk_req("rd_c4", 0, 32'h0); chk_ins("rd_c4", 0, 32'h0, 32'h0); step_cycle();
      drive(1, 1, 32'h2000_0004, 1, 32'h200, 0, 1);
      chk_req("rd_c5", 0, 32'h0); chk_ins("rd_c5", 0, 32'h0, 32'h0); step_cycle();
      drive(1, 1, 32'h2000_0008, 0, 32'h0, 0, 1);
      chk_req("rd_c6", 0, 32'h0); chk("rd_c6_addr", addr, 32'h200);
      chk_ins("rd_c6", 0, 32'h0, 32'h0); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_req("rd_c7", 1, 32'h200); chk_ins("rd_c7", 0, 32'h0, 32'h0); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1); chk_req("rd_c8", 1, 32'h204); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1); chk_ins("rd_c9", 0, 32'h0, 32'h0); step_cycle();
      drive(0, 1, 32'h2000_0200, 0, 32'h0, 0, 0); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_ins("rd_c11", 1, 32'h200, 32'h2000_0200); step_cycle();

      // PC wrap at the top of the address space.
      do_reset();
      drive(0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0); chk_req("wr_c1", 0, 32'h0); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0); chk_req("wr_c2", 1, 32'hFFFF_FFFC); step_cycle();
      drive(1, 1, 32'hAAAA_0001, 0, 32'h0, 0, 0); chk_req("wr_c3", 1, 32'h0); step_cycle();
      drive(0, 1, 32'hAAAA_0002, 0, 32'h0, 0, 1);
      chk_req("wr_c4", 1, 32'h4); chk_ins("wr_c4", 1, 32'hFFFF_FFFC, 32'hAAAA_0001); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_ins("wr_c5", 1, 32'h0, 32'hAAAA_0002); step_cycle();

      // Halt with 2 outstanding on a 3-cycle memory.
      do_reset();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0); chk_req("ht_c1", 1, 32'h0); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0); chk_req("ht_c2", 1, 32'h4); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 1, 0); chk_req("ht_c3", 0, 32'h0); step_cycle();
      drive(1, 1, 32'h3000_0000, 0, 32'h0, 1, 0); chk_req("ht_c4", 0, 32'h0); step_cycle();
      drive(1, 1, 32'h3000_0004, 0, 32'h0, 1, 0);
      chk_ins("ht_c5", 1, 32'h0, 32'h3000_0000); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 1, 1);
      chk_ins("ht_c6", 1, 32'h0, 32'h3000_0000); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 1, 1);
      chk_req("ht_c7", 0, 32'h0); chk_ins("ht_c7", 1, 32'h4, 32'h3000_0004); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_req("ht_c8", 1, 32'h8); chk_ins("ht_c8", 0, 32'h0, 32'h0); step_cycle();

      // Reset mid-stream with three buffered entries and one outstanding.
      do_reset();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0); step_cycle();
      drive(1, 1, 32'h4000_0000, 0, 32'h0, 0, 0); step_cycle();
      drive(1, 1, 32'h4000_0004, 0, 32'h0, 0, 0); step_cycle();
      drive(1, 1, 32'h4000_0008, 0, 32'h0, 0, 0); chk_req("mr_c4", 1, 32'hC); step_cycle();
      drive(1, 1, 32'h4000_000C, 0, 32'h0, 0, 0);
      chk_ins("mr_c5", 1, 32'h0, 32'h4000_0000);
      rst = 1'b0;
      step_cycle();
      rst = 1'b1;
      drive(0, 0, 32'h0, 0, 32'h0, 0, 0);
      chk("mr_req_valid", {31'd0, req_valid}, 32'd0);
      chk("mr_ins_valid", {31'd0, ins_valid}, 32'd0);
      chk("mr_addr", addr, 32'h0);
      chk("mr_ins_pc", ins_pc, 32'h0);
      chk("mr_ins_data", ins_data, 32'h0);
      step_cycle();
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 32'h0, 0, 32'h0, 0, 0);
         chk_req($sformatf("mr_credit%0d", k), 1, 32'(4 * k));
         chk_ins($sformatf("mr_credit%0d", k), 0, 32'h0, 32'h0);
         step_cycle();
      end
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0); chk_req("mr_credit_full", 0, 32'h0); step_cycle();

      // Stray response with nothing outstanding must be ignored.
      do_reset();
      drive(0, 1, 32'hDEAD_BEEF, 0, 32'h0, 0, 1); step_cycle();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 0);
      chk_req("pe_c2", 1, 32'h0); chk_ins("pe_c2", 0, 32'h0, 32'h0); step_cycle();
      drive(0, 1, 32'h5000_0000, 0, 32'h0, 0, 0); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_ins("pe_c4", 1, 32'h0, 32'h5000_0000); step_cycle();

`ifdef FETCH_BYPASS_EN
      // Same-cycle delivery when the buffer is empty and decode is ready.
      do_reset();
      drive(1, 0, 32'h0, 0, 32'h0, 0, 1); chk_req("bp_c1", 1, 32'h0); step_cycle();
      drive(0, 1, 32'h6000_0000, 0, 32'h0, 0, 1);
      chk_ins("bp_c2", 1, 32'h0, 32'h6000_0000); step_cycle();
      drive(0, 0, 32'h0, 0, 32'h0, 0, 1);
      chk_ins("bp_c3", 0, 32'h0, 32'h0); step_cycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction fetch stage; replaces the single PC register, IR and PC mux of the first-generation datapath.
- Issues sequential fetch requests to instruction memory over a valid/ready handshake, with up to FIFO_DEPTH requests outstanding.
- Buffers in-order responses with their PC in a prefetch FIFO and hands {pc, instruction} to decode through a valid/ready handshake.
- Handles redirects (branch/jump) by flushing the buffer and discarding stale responses.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC / memory address width.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2; also the outstanding-request limit.
- RESET_VECTOR, 0, PC value loaded at reset.
- PC_STEP, 4, PC increment per fetched instruction.

Ports:
- fetch_unit_clock_in  in  1  clock; all state updates on the rising edge.
- fetch_unit_reset_in  in  1  reset; synchronous, active-low.
- fetch_unit_imem_req_valid_out  out  1  fetch request valid.
- fetch_unit_imem_req_ready_in  in  1  memory accepts the request.
- fetch_unit_imem_addr_out  out  ADDR_WIDTH  fetch address.
- fetch_unit_imem_resp_valid_in  in  1  response valid; in order, at most one per cycle, at least 1 cycle after accept.
- fetch_unit_imem_data_in  in  DATA_WIDTH  response instruction.
- fetch_unit_redirect_in  in  1  redirect pulse.
- fetch_unit_redirect_addr_in  in  ADDR_WIDTH  redirect target PC.
- fetch_unit_halt_in  in  1  suppress new requests.
- fetch_unit_ins_valid_out  out  1  instruction available to decode.
- fetch_unit_ins_ready_in  in  1  decode accepts the instruction.
- fetch_unit_ins_data_out  out  DATA_WIDTH  instruction.
- fetch_unit_ins_pc_out  out  ADDR_WIDTH  PC of the instruction.

Behaviour:
- Reset (fetch_unit_reset_in = 0 at a clock edge):
  - state = IDLE; req_pc and resp_pc = RESET_VECTOR.
  - FIFO empty; outstanding = 0.
  - All valid outputs 0; ins_data/ins_pc outputs 0.
  - Reset overrides every other input, including mid-transaction; responses to pre-reset requests are the memory's responsibility to cancel.
- State machine:
  - IDLE -> RUN one cycle after reset deasserts.
  - RUN -> FLUSH on redirect when outstanding_next > 0.
  - FLUSH -> RUN when outstanding reaches 0. A further redirect in FLUSH reloads the PCs and stays in FLUSH.
- Request issue:
  - req_valid_out = (state == RUN) and not halt and not redirect_in and (fifo_count + outstanding < FIFO_DEPTH).
  - addr_out = req_pc.
  - On accept (valid and ready): req_pc += PC_STEP, modulo 2^ADDR_WIDTH (wraps silently); outstanding += 1.
  - Once valid is asserted, address is held stable until accepted, unless a redirect occurs.
- Response:
  - Each resp_valid decrements outstanding.
  - In RUN without redirect: push {resp_pc, data}, then resp_pc += PC_STEP. The credit rule guarantees no overflow.
  - In FLUSH, or in the redirect cycle itself: the response is discarded.
  - resp_valid with outstanding == 0 is a protocol error and is ignored (counter saturates at 0).
- Redirect (1 cycle):
  - FIFO cleared.
  - req_pc and resp_pc = redirect_addr.
  - ins_valid_out forced 0 in that cycle.
  - No misalignment check.
- Decode side:
  - ins_valid_out = FIFO non-empty; data/pc outputs come from the FIFO head.
  - Pop on valid and ready.
  - Push and pop in the same cycle is legal at any occupancy, including full.
- Latency: response at cycle t -> ins_valid_out at t+1 (registered FIFO).
- Halt: blocks new requests only; outstanding responses still complete and fill the FIFO.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state is RUN, no redirect, and resp_valid is high, the response drives ins_* combinationally in the same cycle.
  - If ins_ready is also high, the entry is consumed without a push.
  - Otherwise it is pushed as normal.
  - Zero-cycle latency.
- Undefined: no combinational path from imem_* to ins_*; latency 1 cycle.

Decomposition:
- Package fetch_unit_pkg:
  - state encoding localparams IDLE/RUN/FLUSH;
  - default PC_STEP;
  - FIFO entry width helper (ADDR_WIDTH + DATA_WIDTH).
- Sub-module fetch_fifo:
  - parametrised synchronous FIFO of {pc, data} entries;
  - push/pop/clear inputs; count, empty and full outputs;
  - pointers wrap mod FIFO_DEPTH.
- Counters and FSM stay in fetch_unit.

Test Plan:
- Reset release, req_ready = 1, 1-cycle memory, ins_ready = 1 -> requests at 0x0, 0x4, 0x8…; instructions emerge in order with matching pc.
- ins_ready = 0, DEPTH = 4 -> exactly 4 requests accepted, then req_valid = 0. Raise ready -> 4 pops, refill resumes.
- Redirect to 0x100 with 3 outstanding (3-cycle memory) -> FLUSH; 3 stale responses dropped, no ins_valid; next request addr 0x100 only after outstanding = 0.
- req_pc = 0xFFFFFFFC, accept -> next addr 0x00000000; pc_out wraps identically.
- Halt asserted with 2 outstanding -> no new requests; both responses delivered; deassert -> issue resumes at the correct next PC.
- Reset asserted mid-stream with FIFO at 3 entries -> next cycle ins_valid = 0, addr = RESET_VECTOR, counters 0. With FETCH_BYPASS_EN, empty FIFO and ready = 1 -> ins_valid in the same cycle as resp_valid.
